// File: rtl/qspi_ram_bridge.sv
// QSPI quad-I/O target giving an external host write/read access to the host port of the shared RAM.
// Defining QSPI_BRIDGE_STATUS_EN adds command 0x05, which reads back a count of bytes written since reset.
module qspi_ram_bridge #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  qspi_sck,
  input  logic                  qspi_cs_n,
  input  logic [3:0]            qspi_io_i,
  output logic [3:0]            qspi_io_o,
  output logic                  qspi_io_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [7:0]            ram_rdata,
  output logic [7:0]            ram_wdata,
  output logic                  ram_wen
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE} state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h38;
  localparam logic [7:0] CMD_READ   = 8'hEB;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

  logic       sck_p0_q, sck_p1_q, sck_p2_q;
  logic       cs_p0_q, cs_p1_q, cs_p2_q;
  logic [3:0] io_p0_q, io_p1_q;
  logic       sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q;
  logic       sck_rise_d, sck_fall_d, cs_rise_d, cs_fall_d;

  state_t                state_q, state_d;
  logic                  half_q, half_d;
  logic                  rd_q, rd_d;
  logic                  status_q, status_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [3:0]            dcnt_q, dcnt_d;
  logic                  fetch_p0_q, fetch_p0_d;
  logic                  fetch_p1_q, fetch_p1_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_wdata_q, ram_wdata_d;
  logic                  ram_wen_q, ram_wen_d;
  logic [3:0]            io_o_q, io_o_d;
  logic                  io_oe_q, io_oe_d;
  logic [3:0]            hi_q, hi_d;
  logic [7:0]            tx_q, tx_d;
  logic [3:0]            hold_q, hold_d;

  logic [7:0] rx_byte;
  logic [7:0] fetch_byte;
  logic       rx_phase;
  logic       byte_done;

  // Synchronizer stage: CS_n resets low so a bridge leaving reset with CS_n already low lands in IGNORE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_p0_q   <= 1'b0;
      sck_p1_q   <= 1'b0;
      sck_p2_q   <= 1'b0;
      cs_p0_q    <= 1'b0;
      cs_p1_q    <= 1'b0;
      cs_p2_q    <= 1'b0;
      io_p0_q    <= '0;
      io_p1_q    <= '0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
    end else begin
      sck_p0_q   <= qspi_sck;
      sck_p1_q   <= sck_p0_q;
      sck_p2_q   <= sck_p1_q;
      cs_p0_q    <= qspi_cs_n;
      cs_p1_q    <= cs_p0_q;
      cs_p2_q    <= cs_p1_q;
      io_p0_q    <= qspi_io_i;
      io_p1_q    <= io_p0_q;
      sck_rise_q <= sck_rise_d;
      sck_fall_q <= sck_fall_d;
      cs_rise_q  <= cs_rise_d;
      cs_fall_q  <= cs_fall_d;
    end
  end

  always_comb begin
    sck_rise_d = sck_p1_q & ~sck_p2_q;
    sck_fall_d = ~sck_p1_q & sck_p2_q;
    cs_rise_d  = cs_p1_q & ~cs_p2_q;
    cs_fall_d  = ~cs_p1_q & cs_p2_q;
  end

`ifdef QSPI_BRIDGE_STATUS_EN
  logic [7:0] wr_cnt_q, wr_cnt_d;

  always_comb wr_cnt_d = wr_cnt_q + {7'd0, ram_wen_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_cnt_q <= '0;
    else        wr_cnt_q <= wr_cnt_d;
  end

  assign fetch_byte = status_q ? wr_cnt_q : ram_rdata;
`else
  assign fetch_byte = ram_rdata;
`endif

  // Decode stage: transaction FSM
  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    rd_d        = rd_q;
    status_d    = status_q;
    ptr_d       = ptr_q;
    dcnt_d      = dcnt_q;
    fetch_p0_d  = 1'b0;
    fetch_p1_d  = fetch_p0_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wen_d   = 1'b0;
    io_o_d      = io_o_q;
    io_oe_d     = io_oe_q;
    hi_d        = hi_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    rx_byte     = {hi_q, io_p1_q};
    rx_phase    = (state_q == CMD) || (state_q == ADDR) || (state_q == WDATA);
    byte_done   = rx_phase && sck_rise_q && half_q;

    // RAM data lands one clk after ram_addr, so the capture trails the request by two clks
    if (fetch_p1_q) tx_d = fetch_byte;

    if (rx_phase && sck_rise_q) begin
      half_d = ~half_q;
      if (!half_q) hi_d = io_p1_q;
    end

    if (cs_rise_q) begin
      state_d = IDLE;
      half_d  = 1'b0;
      io_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          io_oe_d = 1'b0;
          if (cs_fall_q) begin
            state_d  = CMD;
            half_d   = 1'b0;
            status_d = 1'b0;
          end else if (!cs_p2_q) begin
            state_d = IGNORE;
          end
        end
        CMD: begin
          if (byte_done) begin
            dcnt_d = '0;
            if (rx_byte == CMD_WRITE) begin
              state_d = ADDR;
              rd_d    = 1'b0;
            end else if (rx_byte == CMD_READ) begin
              state_d = ADDR;
              rd_d    = 1'b1;
`ifdef QSPI_BRIDGE_STATUS_EN
            end else if (rx_byte == CMD_STATUS) begin
              state_d  = DUMMY;
              status_d = 1'b1;
`endif
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR: begin
          if (byte_done) begin
            ptr_d   = ADDR_WIDTH'(rx_byte);
            state_d = rd_q ? DUMMY : WDATA;
          end
        end
        WDATA: begin
          if (byte_done) begin
            ram_addr_d  = ptr_q;
            ram_wdata_d = rx_byte;
            ram_wen_d   = 1'b1;
            ptr_d       = ptr_q + 1'b1;
          end
        end
        DUMMY: begin
          if (sck_rise_q) begin
            if (dcnt_q == '0) begin
              fetch_p0_d = 1'b1;
              if (!status_q) ram_addr_d = ptr_q;
            end
            if (dcnt_q == DUMMY_LAST) begin
              state_d = RDATA;
              half_d  = 1'b0;
            end
            dcnt_d = dcnt_q + 4'd1;
          end
        end
        RDATA: begin
          if (sck_fall_q) begin
            io_oe_d = 1'b1;
            if (!half_q) begin
              io_o_d     = tx_q[7:4];
              hold_d     = tx_q[3:0];
              half_d     = 1'b1;
              fetch_p0_d = 1'b1;
              if (!status_q) begin
                ptr_d      = ptr_q + 1'b1;
                ram_addr_d = ptr_q + 1'b1;
              end
            end else begin
              io_o_d = hold_q;
              half_d = 1'b0;
            end
          end
        end
        default: io_oe_d = 1'b0;
      endcase
    end
  end

  // Register stage: control and host-visible outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      half_q      <= 1'b0;
      rd_q        <= 1'b0;
      status_q    <= 1'b0;
      ptr_q       <= '0;
      dcnt_q      <= '0;
      fetch_p0_q  <= 1'b0;
      fetch_p1_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wen_q   <= 1'b0;
      io_o_q      <= '0;
      io_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      rd_q        <= rd_d;
      status_q    <= status_d;
      ptr_q       <= ptr_d;
      dcnt_q      <= dcnt_d;
      fetch_p0_q  <= fetch_p0_d;
      fetch_p1_q  <= fetch_p1_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wen_q   <= ram_wen_d;
      io_o_q      <= io_o_d;
      io_oe_q     <= io_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    tx_q   <= tx_d;
    hold_q <= hold_d;
  end

  assign qspi_io_o  = io_o_q;
  assign qspi_io_oe = io_oe_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_wen    = ram_wen_q;

endmodule
